// File: rtl/datapath_control_if.sv
// Control-side signal bundle between datapath_control and the shared-bus datapath.
// master = control unit, slave = datapath (or bench standing in for it).
interface datapath_control_if;
    logic        run;
    logic [7:0]  ISR;
    logic [15:0] rout;
    logic [15:0] ren;
    logic        addxor;
    logic        done;
    logic [1:0]  tstep;

    modport master (
        input  run, ISR,
        output rout, ren, addxor, done, tstep
    );

    modport slave (
        output run, ISR,
        input  rout, ren, addxor, done, tstep
    );
endinterface

// File: rtl/datapath_control.sv
// Step sequencer for the shared-bus register datapath: fetch in T0, then mv/mvi finish in T1,
// add/xor go A <= Rx, G <= A op Ry, Rx <= G over T1..T3.
module datapath_control (
    input logic          clock,
    input logic          resetnot,
    datapath_control_if.master bus
);

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    state_t      state;
    logic [1:0]  opcode;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] rx_sel;
    logic [15:0] ry_sel;
    logic [15:0] rout;
    logic [15:0] ren;
    logic        addxor;
    logic        done;

    assign opcode = bus.ISR[7:6];
    assign rx     = bus.ISR[5:3];
    assign ry     = bus.ISR[2:0];
    assign rx_sel = 16'd1 << rx;
    assign ry_sel = 16'd1 << ry;

    always_ff @(posedge clock or negedge resetnot) begin
        if (!resetnot) begin
            state <= T0;
        end else begin
            case (state)
                T0:      state <= bus.run ? T1 : T0;
                T1:      state <= opcode[1] ? T2 : T0;
                T2:      state <= T3;
                T3:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    // Outputs follow the state and the live ISR, so they track the fetch edge directly.
    always_comb begin
        rout   = 16'h0000;
        ren    = 16'h0000;
        addxor = 1'b0;
        done   = 1'b0;
        case (state)
            T0: begin
                ren[11] = bus.run;
            end
            T1: begin
                if (!opcode[1]) begin
                    rout = opcode[0] ? 16'h0400 : ry_sel;
                    ren  = rx_sel;
                    done = 1'b1;
                end else begin
                    rout = rx_sel;
                    ren  = 16'h0200;
                end
            end
            T2: begin
                rout   = ry_sel;
                ren    = 16'h0100;
                addxor = opcode[0];
            end
            T3: begin
                rout = 16'h0100;
                ren  = rx_sel;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.rout   = rout;
    assign bus.ren    = ren;
    assign bus.addxor = addxor;
    assign bus.done   = done;
    assign bus.tstep  = state;

endmodule

// File: doc/datapath_control.md
# datapath_control

Control unit that sequences the shared-bus register datapath. It loads each instruction byte into the datapath's instruction register, decodes it, and drives the one-hot bus-source selects (`rout`), the register load enables (`ren`) and the ALU function select (`addxor`) step by step until the instruction completes. It sits beside the datapath: its outputs connect directly to the datapath's control inputs, and the datapath's `ISR` output feeds back into it.

## Interface
Parameters: none. The field positions, opcodes and bus-slot numbering are fixed by the datapath.

- `clock`  in  1  — single clock; all state changes on the rising edge.
- `resetnot`  in  1  — asynchronous, active-low reset.
- `run`  in  1  — start request; sampled only in T0.
- `ISR`  in  8  — instruction register contents from the datapath. Fields: [7:6] opcode, [5:3] Rx, [2:0] Ry / immediate.
- `rout`  out  16  — bus source select, at most one bit high:
  - [7:0] = R0..R7
  - [8] = G
  - [9] = A
  - [10] = EXTERN (immediate ISR[2:0])
  - [15:11] always 0.
- `ren`  out  16  — register load enables:
  - [7:0] = R0..R7
  - [8] = G
  - [9] = A
  - [11] = ISR
  - [10] and [15:12] always 0.
- `addxor`  out  1  — ALU function: 0 = add, 1 = xor.
- `done`  out  1  — high during the final step of an instruction.
- `tstep`  out  2  — current step (0..3), exposed for debug.

## Operation
Opcodes:
- 00 `mv Rx,Ry`
- 01 `mvi Rx,#ISR[2:0]`
- 10 `add Rx,Ry`
- 11 `xor Rx,Ry`

States T0..T3 are encoded as `tstep` 0..3. Outputs are combinational from (state, ISR, run). Every bit not listed for a step is 0.

- **T0 (idle/fetch):**
  - `ren[11]` = `run`.
  - If `run`, go to T1; else stay in T0.
  - ISR captures the instruction on this edge.
- **T1:**
  - mv: `rout[Ry]`, `ren[Rx]`, `done`; go to T0.
  - mvi: `rout[10]`, `ren[Rx]`, `done`; go to T0.
  - add/xor: `rout[Rx]`, `ren[9]` (A <= Rx); go to T2.
- **T2 (add/xor only):**
  - `rout[Ry]`, `ren[8]` (G <= alu).
  - `addxor` = ISR[6] (0 for add, 1 for xor).
  - Go to T3.
- **T3 (add/xor only):**
  - `rout[8]`, `ren[Rx]`, `done`.
  - Go to T0.

Rules:
- `addxor` is 0 in every step except T2.
- `run` is ignored outside T0. No queuing: a pulse during T1–T3 is lost.
- Rx = Ry is legal; the same index drives both `rout` and `ren`.
- Unreachable state encodings are not used. If one is entered anyway, it returns to T0 on the next edge with all outputs 0.

## Timing
- **Reset:** `resetnot` low forces state T0 immediately, without waiting for a clock edge.
  - `rout` = 0, `addxor` = 0, `done` = 0, `tstep` = 0.
  - `ren` = 0 while `run` is low.
  - This holds for a reset mid-instruction. The partially executed instruction is abandoned, and registers already written keep their values.
- **Latency from the T0 edge with `run`=1:**
  - mv/mvi complete 2 cycles later (T0, T1).
  - add/xor complete 4 cycles later (T0..T3).
- **`done`:** one-cycle pulse coincident with the final register write.
- **Back-to-back:** with `run` held high, T0 follows the done step immediately and fetches the next instruction. Throughput is 2 or 4 cycles per instruction with no bubble.
- **Bus ownership:** `rout` changes only at clock edges and with ISR. The bus floats (`rout` = 0) in T0.

## Test plan
- **mvi:** Reset, then `run`=1 for one cycle with instruction 8'b01_000_101 (`mvi R0,#5`).
  - T0: `ren`=0x0800.
  - T1: `rout`=0x0400, `ren`=0x0001, `done`=1.
  - Then T0 with all outputs 0, and R0=5 in the datapath.
- **mv:** Instruction 8'b00_111_000 (`mv R7,R0`).
  - T1: `rout`=0x0001, `ren`=0x0080, `done`=1, `tstep`=1.
- **add:** Instruction 8'b10_001_010 (`add R1,R2`).
  - T1: `rout`=0x0002, `ren`=0x0200.
  - T2: `rout`=0x0004, `ren`=0x0100, `addxor`=0.
  - T3: `rout`=0x0100, `ren`=0x0002, `done`=1.
- **xor:** Instruction 8'b11_011_011 (`xor R3,R3`).
  - T2: `addxor`=1.
  - T3: `ren`=0x0008.
  - With R3=6, R3 ends at 0.
- **Reset mid-instruction and ignored run:**
  - Drive `resetnot` low mid-T2 of an add: all outputs drop to 0 before the next edge, and `tstep`=0.
  - Separately, pulse `run` during T2: it is ignored, and T0 is followed by T0 (no fetch).
- **Back-to-back:** Hold `run`=1 across `mvi R2,#3` then `add R2,R2`.
  - `done` pulses at cycles 1 and 5.
  - R2=6 at the end.
  - At most one `rout` bit is set in every cycle.
